// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : core_sequencer
//  Purpose  : Board-level run controller for a soft core. Debounces nothing,
//             but synchronizes the board switches/button, holds the core in
//             reset on enable, and paces the core with a one-cycle clock
//             enable in RUN (divided rate), STEP (single pulse) or not at
//             all (HOLD / HALT / TRAPPED).
//  Ports    : clk          - single clock, rising edge
//             reset        - synchronous active-high reset
//             sw_en        - async core enable switch (low forces HOLD)
//             sw_run       - async run/halt switch
//             btn_step     - async single-step button (rising edge = step)
//             div_sel[1:0] - run-rate select
//             trap_i       - trap flag from the core
//             pc_i[31:0]   - program counter from the core
//             core_resetn  - registered active-low reset to the core
//             core_ce      - one-cycle core clock-enable pulse
//             led[11:0]    - status display (state flags + pc_q[8:0])
//             state_o[2:0] - HOLD=0 HALT=1 RUN=2 STEP=3 TRAPPED=4
//  Revision : 1.0 - initial release
// ============================================================================
module core_sequencer #(
   parameter int DIV_W       = 16,
   parameter int HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sw_en,
   input  logic        sw_run,
   input  logic        btn_step,
   input  logic [1:0]  div_sel,
   input  logic        trap_i,
   input  logic [31:0] pc_i,
   output logic        core_resetn,
   output logic        core_ce,
   output logic [11:0] led,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_HALT    = 3'd1,
      ST_RUN     = 3'd2,
      ST_STEP    = 3'd3,
      ST_TRAPPED = 3'd4
   } state_t;

   localparam int                c_HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DIV_W-1:0]  c_ALL_ONES = {DIV_W{1'b1}};

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_en_sync;
   logic [1:0]          r_run_sync;
   logic [1:0]          r_btn_sync;
   logic                r_btn_d;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic [DIV_W-1:0]    r_ctr;
   logic [DIV_W-1:0]    w_tc;
   logic [31:0]         r_pc_q;
   logic                r_core_resetn;
   logic                w_core_ce;
   logic                w_en_s;
   logic                w_run_s;
   logic                w_btn_s;
   logic                w_step_evt;
   logic                w_tick;
   logic                w_unused_pc;

   assign w_en_s     = r_en_sync[1];
   assign w_run_s    = r_run_sync[1];
   assign w_btn_s    = r_btn_sync[1];
   assign w_step_evt = w_btn_s & ~r_btn_d;

   // Terminal count: the divider period shrinks by 16x per div_sel step,
   // with div_sel=3 giving an enable on every RUN cycle.
   always_comb begin
      w_tc = '0;
      case (div_sel)
         2'd0:    w_tc = c_ALL_ONES;
         2'd1:    w_tc = c_ALL_ONES >> 4;
         2'd2:    w_tc = c_ALL_ONES >> 8;
         default: w_tc = '0;
      endcase
   end

   // An out-of-range ctr (after a div_sel reduction) never matches TC, so the
   // wrap cycle produces no enable.
   assign w_tick = (r_ctr == w_tc);

   // ------------------------------------------------------------------------
   // State register and datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_HOLD;
         r_en_sync     <= '0;
         r_run_sync    <= '0;
         r_btn_sync    <= '0;
         r_btn_d       <= 1'b0;
         r_hold_cnt    <= '0;
         r_ctr         <= '0;
         r_pc_q        <= '0;
         r_core_resetn <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_en_sync     <= {r_en_sync[0],  sw_en};
         r_run_sync    <= {r_run_sync[0], sw_run};
         r_btn_sync    <= {r_btn_sync[0], btn_step};
         r_btn_d       <= w_btn_s;
         r_pc_q        <= pc_i;
         // Registered from the next state so it lines up with state_o.
         r_core_resetn <= (w_state_nxt != ST_HOLD);

         // Counts consecutive enabled cycles in HOLD; any disabled cycle or
         // any other state restarts it.
         if ((r_state == ST_HOLD) && w_en_s) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
         end else begin
            r_hold_cnt <= '0;
         end

         // Held at zero outside RUN so every entry to RUN starts a full period.
         if (r_state == ST_RUN) begin
            if (r_ctr >= w_tc) begin
               r_ctr <= '0;
            end else begin
               r_ctr <= r_ctr + DIV_W'(1);
            end
         end else begin
            r_ctr <= '0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and clock-enable decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_core_ce   = 1'b0;

      case (r_state)
         ST_HOLD: begin
            if (w_en_s && (r_hold_cnt == c_HOLD_LAST)) begin
               w_state_nxt = w_run_s ? ST_RUN : ST_HALT;
            end
         end
         ST_HALT: begin
            if (!w_en_s) begin
               w_state_nxt = ST_HOLD;
            end else if (w_run_s) begin
               w_state_nxt = ST_RUN;
            end else if (w_step_evt) begin
               w_state_nxt = ST_STEP;
            end
         end
         ST_STEP: begin
            if (!w_en_s) begin
               w_state_nxt = ST_HOLD;
            end else if (trap_i) begin
               w_state_nxt = ST_TRAPPED;
            end else begin
               w_core_ce   = 1'b1;
               w_state_nxt = ST_HALT;
            end
         end
         ST_RUN: begin
            if (!w_en_s) begin
               w_state_nxt = ST_HOLD;
            end else if (trap_i) begin
               w_state_nxt = ST_TRAPPED;
            end else if (!w_run_s) begin
               w_state_nxt = ST_HALT;
            end else begin
               w_core_ce = w_tick;
            end
         end
         ST_TRAPPED: begin
            if (!w_en_s) begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_HOLD;
         end
      endcase
   end

   // Reset gates the enable combinationally so a core mid-step or mid-run
   // never sees a pulse on the cycle reset is applied.
   assign core_ce     = w_core_ce & ~reset;
   assign core_resetn = r_core_resetn;
   assign state_o     = r_state;

   assign led = {r_pc_q[8:6], (r_state == ST_HALT),
                 r_pc_q[5:3], (r_state == ST_RUN),
                 r_pc_q[2:0], (r_state == ST_TRAPPED)};

   // Upper PC bits are captured but not displayed.
   assign w_unused_pc = ^r_pc_q[31:9];

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_sequencer
//  Purpose  : Directed self-checking bench for core_sequencer (DIV_W=12,
//             HOLD_CYCLES=4). Inputs change and outputs are sampled on the
//             falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        sw_en;
   logic        sw_run;
   logic        btn_step;
   logic [1:0]  div_sel;
   logic        trap_i;
   logic [31:0] pc_i;
   logic        core_resetn;
   logic        core_ce;
   logic [11:0] led;
   logic [2:0]  state_o;

   int n_checks = 0;
   int n_errors = 0;

   core_sequencer #(
      .DIV_W       (12),
      .HOLD_CYCLES (4)
   ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .sw_en       (sw_en),
      .sw_run      (sw_run),
      .btn_step    (btn_step),
      .div_sel     (div_sel),
      .trap_i      (trap_i),
      .pc_i        (pc_i),
      .core_resetn (core_resetn),
      .core_ce     (core_ce),
      .led         (led),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Bounded wait for a state; a timeout shows up as a failed comparison.
   task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
      int n;
      n = 0;
      while ((state_o !== st) && (n < budget)) begin
         tick();
         n++;
      end
      check_val(tag, {29'd0, state_o}, {29'd0, st});
   endtask

   // Counts enables over n cycles, starting with the current one.
   task automatic count_ce(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         if (core_ce === 1'b1) pulses++;
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int rise_at;
      int ce_seen;
      int ce_edge;
      int pulses;
      int low_cnt;
      int first_ce;
      int n;

      reset    = 1'b1;
      sw_en    = 1'b0;
      sw_run   = 1'b0;
      btn_step = 1'b0;
      div_sel  = 2'd0;
      trap_i   = 1'b0;
      pc_i     = 32'd0;

      // ---------------- reset state
      @(negedge clk);
      check_val("rst_state",  {29'd0, state_o}, 32'd0);
      check_val("rst_resetn", {31'd0, core_resetn}, 32'd0);
      check_val("rst_ce",     {31'd0, core_ce}, 32'd0);
      check_val("rst_led",    {20'd0, led}, 32'd0);
      reset = 1'b0;

      // ---------------- hold release into HALT
      sw_en   = 1'b1;
      sw_run  = 1'b0;
      rise_at = 0;
      ce_seen = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (core_ce === 1'b1) ce_seen++;
         if ((core_resetn === 1'b1) && (rise_at == 0)) rise_at = i;
      end
      check_val("hold_release_edge", rise_at, 32'd6);
      check_val("hold_release_state", {29'd0, state_o}, 32'd1);
      check_val("hold_release_no_ce", ce_seen, 32'd0);

      // ---------------- single step, button held 50 cycles
      btn_step = 1'b1;
      pulses   = 0;
      ce_edge  = 0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (core_ce === 1'b1) begin
            pulses++;
            if (ce_edge == 0) ce_edge = i + 1;
         end
      end
      check_val("step_pulses", pulses, 32'd1);
      check_val("step_edge", ce_edge, 32'd4);
      check_val("step_back_halt", {29'd0, state_o}, 32'd1);
      btn_step = 1'b0;
      tick();
      tick();

      // ---------------- run rate, div_sel=2 (every 16) then 3 (every cycle)
      div_sel = 2'd2;
      sw_run  = 1'b1;
      wait_state("enter_run", 3'd2, 20);
      count_ce(100, pulses);
      check_val("run_div2_pulses", pulses, 32'd6);
      check_val("run_div2_state", {29'd0, state_o}, 32'd2);
      // ctr is 4 here, beyond the new TC of 0: wrap cycle, no enable.
      div_sel = 2'd3;
      #1;
      check_val("div_shrink_wrap_no_ce", {31'd0, core_ce}, 32'd0);
      tick();
      count_ce(100, pulses);
      check_val("run_div3_pulses", pulses, 32'd100);

      // ---------------- trap priority over a coincident tick
      trap_i = 1'b1;
      #1;
      check_val("trap_ce_suppressed", {31'd0, core_ce}, 32'd0);
      tick();
      trap_i = 1'b0;
      #1;
      check_val("trap_state", {29'd0, state_o}, 32'd4);
      check_val("trap_led0", {31'd0, led[0]}, 32'd1);
      check_val("trap_resetn", {31'd0, core_resetn}, 32'd1);
      ce_seen = 0;
      for (int i = 0; i < 8; i++) begin
         btn_step = ~btn_step;
         sw_run   = ~sw_run;
         count_ce(3, pulses);
         ce_seen += pulses;
      end
      check_val("trap_ignores_inputs", ce_seen, 32'd0);
      check_val("trap_stays", {29'd0, state_o}, 32'd4);

      // ---------------- recovery via sw_en 1->0->1 with sw_run=1
      div_sel = 2'd2;
      sw_en   = 1'b0;
      low_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (core_resetn === 1'b0) low_cnt++;
      end
      sw_en = 1'b1;
      n = 0;
      while ((state_o !== 3'd2) && (n < 20)) begin
         tick();
         if (core_resetn === 1'b0) low_cnt++;
         n++;
      end
      check_val("recover_low_cycles", low_cnt, 32'd8);
      check_val("recover_run", {29'd0, state_o}, 32'd2);
      check_val("recover_resetn", {31'd0, core_resetn}, 32'd1);
      // A fresh ctr=0 puts the first enable on the 16th RUN cycle.
      first_ce = -1;
      for (int i = 0; i < 40; i++) begin
         if ((core_ce === 1'b1) && (first_ce < 0)) first_ce = i;
         tick();
      end
      check_val("recover_ctr_zero", first_ce, 32'd15);

      // ---------------- LED map
      pc_i = 32'h0000_01A5;
      #1;
      check_val("led_before_pc", {20'd0, led}, 32'h010);
      tick();
      check_val("led_pc_1a5", {20'd0, led}, 32'hC9A);

      // ---------------- reset mid-RUN suppresses the enable immediately
      div_sel = 2'd3;
      tick();
      tick();
      check_val("pre_reset_ce", {31'd0, core_ce}, 32'd1);
      reset = 1'b1;
      #1;
      check_val("reset_kills_ce", {31'd0, core_ce}, 32'd0);
      tick();
      check_val("reset_state", {29'd0, state_o}, 32'd0);
      check_val("reset_resetn", {31'd0, core_resetn}, 32'd0);
      check_val("reset_led", {20'd0, led}, 32'd0);
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, giving the run-rate divider counter width (minimum 9).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles the core is held in reset on entry to HOLD (minimum 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port sw_en, input, 1 bit, asynchronous: core enable switch; low forces HOLD.
REQ-006 The block SHALL have port sw_run, input, 1 bit, asynchronous: run (1) or halt (0) switch.
REQ-007 The block SHALL have port btn_step, input, 1 bit, asynchronous: single-step button; its rising edge requests one step.
REQ-008 The block SHALL have port div_sel, input, 2 bits: run-rate select, sampled every cycle.
REQ-009 The block SHALL have port trap_i, input, 1 bit: trap flag from the core.
REQ-010 The block SHALL have port pc_i, input, 32 bits: program counter from the core.
REQ-011 The block SHALL have port core_resetn, output, 1 bit: active-low reset to the core.
REQ-012 The block SHALL have port core_ce, output, 1 bit: one-cycle core clock-enable pulse.
REQ-013 The block SHALL have port led, output, 12 bits: board status display.
REQ-014 The block SHALL have port state_o, output, 3 bits: FSM state encoding HOLD=0, HALT=1, RUN=2, STEP=3, TRAPPED=4.

Function
REQ-015 The block SHALL pass sw_en, sw_run and btn_step through 2-flop synchronizers; en_s, run_s and btn_s denote the synchronizer outputs.
REQ-016 The block SHALL assert step_evt when btn_s=1 and the previous-cycle btn_s=0.
REQ-017 HOLD SHALL hold core_resetn=0 and core_ce=0, count HOLD_CYCLES cycles with en_s=1, then go to RUN if run_s=1, otherwise to HALT.
REQ-018 In HOLD, the hold counter SHALL restart from 0 whenever en_s=0.
REQ-019 In every state except HOLD, en_s=0 SHALL force the next state to HOLD with core_ce=0; this takes priority over every other condition.
REQ-020 In HALT, run_s=1 SHALL go to RUN; otherwise step_evt=1 SHALL go to STEP; core_ce=0 in HALT.
REQ-021 STEP SHALL last exactly one cycle with core_ce=1, then go to HALT.
REQ-022 In STEP, trap_i=1 SHALL suppress core_ce and go to TRAPPED.
REQ-023 In RUN, the divider counter ctr[DIV_W-1:0] SHALL increment by 1 each cycle, wrapping to 0 at terminal count TC.
REQ-024 TC SHALL be: div_sel=0 -> 2^DIV_W-1; 1 -> 2^(DIV_W-4)-1; 2 -> 2^(DIV_W-8)-1; 3 -> 0 (core_ce every cycle).
REQ-025 In RUN, core_ce SHALL be 1 exactly on cycles where ctr==TC and trap_i=0 and run_s=1 and en_s=1.
REQ-026 If div_sel changes so that ctr>TC, ctr SHALL wrap to 0 on the next cycle, with no core_ce on that cycle.
REQ-027 In RUN, run_s=0 SHALL go to HALT with no core_ce that cycle; step_evt SHALL be ignored in RUN.
REQ-028 In RUN, trap_i=1 SHALL go to TRAPPED; trap takes priority over a coincident tick, so core_ce=0 that cycle.
REQ-029 TRAPPED SHALL hold core_ce=0 and core_resetn=1, and SHALL be exited only via en_s=0 (to HOLD); step_evt and run_s SHALL be ignored.
REQ-030 ctr SHALL be cleared to 0 on every entry to RUN.
REQ-031 step_evt SHALL NOT be queued: an edge arriving outside HALT is discarded.
REQ-032 core_resetn SHALL be 0 in HOLD and 1 in all other states, and SHALL be registered.
REQ-033 core_ce SHALL be combinational from state, ctr, trap_i and the synchronized inputs only.
REQ-034 The block SHALL register pc_i every cycle into pc_q.
REQ-035 The led mapping SHALL be: led[0]=(state==TRAPPED); led[3:1]=pc_q[2:0]; led[4]=(state==RUN); led[7:5]=pc_q[5:3]; led[8]=(state==HALT); led[11:9]=pc_q[8:6].

Reset
REQ-036 reset=1 SHALL force state=HOLD, hold counter=0, ctr=0, pc_q=0, all synchronizer and edge flops=0, core_resetn=0, core_ce=0 and led=0 on the next edge.
REQ-037 Reset asserted mid-STEP or mid-RUN SHALL suppress core_ce in that same cycle.

Verification
REQ-038 Hold-release: reset 1 cycle, then sw_en=1, sw_run=0 -> core_resetn rises HOLD_CYCLES (4) cycles after en_s=1, state_o=1, core_ce never asserted.
REQ-039 Run-rate: DIV_W=12, div_sel=2, state RUN -> core_ce pulses exactly every 16 cycles; with div_sel=3, every cycle; 100 cycles produce 6 and 100 pulses respectively.
REQ-040 Single step: HALT, btn_step rises and holds 50 cycles -> exactly one core_ce pulse, on the 4th edge after the first edge sampling btn_step=1; state returns to HALT.
REQ-041 Trap priority: RUN with div_sel=3, trap_i=1 for one cycle -> core_ce=0 that cycle, state_o=4, led[0]=1; subsequent btn_step and sw_run toggles produce no core_ce.
REQ-042 Recovery: from TRAPPED, sw_en 1->0->1 -> core_resetn=0 for at least 4 cycles, then RUN (if sw_run=1) with ctr=0.
REQ-043 LED map: pc_i=0x1A5 held -> led[11:9]=6, led[7:5]=4, led[3:1]=5, one cycle after pc_i is applied.
